execute_stage: RTL

Execute stage of the five-stage MIPS pipeline. It consumes the E-stage signals held by the decode-to-execute register and applies hazard-unit forwarding. It computes the ALU result, including a multi-cycle iterative MUL, selects the destination register, and registers everything into the execute-to-memory pipeline register. During a MUL it asserts `BusyE` so the hazard unit stalls F/D and flushes E until the product is ready.

---
 rtl/execute_stage_if.sv | 40 ++++
 rtl/execute_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs and execute-to-memory outputs of the MIPS execute stage.
// The execute stage uses the slave view; the decode/hazard side uses the master view.
interface execute_stage_if;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic        MemWriteE;
   logic        ALUSrcE;
   logic        RegDstE;
   logic [2:0]  ALUControlE;
   logic [31:0] data1E;
   logic [31:0] data2E;
   logic [4:0]  RtE;
   logic [4:0]  RdE;
   logic [31:0] SignImmE;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic [31:0] ResultW;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [4:0]  WriteRegM;
   logic [4:0]  WriteRegE;
   logic        BusyE;

   modport slave (
      input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
      input  data1E, data2E, RtE, RdE, SignImmE, ForwardAE, ForwardBE, ResultW,
      output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
      output WriteRegE, BusyE
   );

   modport master (
      output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
      output data1E, data2E, RtE, RdE, SignImmE, ForwardAE, ForwardBE, ResultW,
      input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
      input  WriteRegE, BusyE
   );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: forwarding muxes, ALU, 32-iteration shift-add multiplier
// and the execute-to-memory pipeline register.
module execute_stage (
   input  logic            clk,
   input  logic            reset,
   execute_stage_if.slave  ex
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] w_src_a, w_write_data, w_src_b, w_alu_res;
   logic [4:0]  w_write_reg;
   logic        w_mul_op, w_mul_start;
   logic [31:0] r_mul_a, r_mul_b, r_acc;
   logic [4:0]  r_count;
   logic        r_hold_regwrite, r_hold_memtoreg, r_hold_memwrite;
   logic [4:0]  r_hold_wreg;
   logic [31:0] r_hold_wdata;

   function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_val,
                                           input logic [31:0] wb_val, input logic [31:0] mem_val);
      case (sel)
         2'b01:   fwd_sel = wb_val;
         2'b10:   fwd_sel = mem_val;
         default: fwd_sel = reg_val;
      endcase
   endfunction

   // MUL (011) never goes through here; its result comes from the accumulator.
   function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (ctl)
         3'b000:  alu_op = a & b;
         3'b001:  alu_op = a | b;
         3'b010:  alu_op = a + b;
         3'b110:  alu_op = a - b;
         3'b111:  alu_op = {31'd0, (sa < sb)};
         default: alu_op = 32'd0;
      endcase
   endfunction

   always_comb begin
      w_src_a      = fwd_sel(ex.ForwardAE, ex.data1E, ex.ResultW, ex.ALUOutM);
      w_write_data = fwd_sel(ex.ForwardBE, ex.data2E, ex.ResultW, ex.ALUOutM);
      w_src_b      = ex.ALUSrcE ? ex.SignImmE : w_write_data;
      w_write_reg  = ex.RegDstE ? ex.RdE : ex.RtE;
      w_alu_res    = alu_op(ex.ALUControlE, w_src_a, w_src_b);
      w_mul_op     = (ex.ALUControlE == 3'b011);
      w_mul_start  = (r_state == S_IDLE) && w_mul_op;
   end

   assign ex.WriteRegE = w_write_reg;
   assign ex.BusyE     = w_mul_start || (r_state == S_RUN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_mul_op) w_state_nxt = S_RUN;
         S_RUN:   if (r_count == 5'd31) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Multiplier datapath and the instruction context held while it iterates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mul_a         <= 32'd0;
         r_mul_b         <= 32'd0;
         r_acc           <= 32'd0;
         r_count         <= 5'd0;
         r_hold_regwrite <= 1'b0;
         r_hold_memtoreg <= 1'b0;
         r_hold_memwrite <= 1'b0;
         r_hold_wreg     <= 5'd0;
         r_hold_wdata    <= 32'd0;
      end else if (w_mul_start) begin
         r_mul_a         <= w_src_a;
         r_mul_b         <= w_src_b;
         r_acc           <= 32'd0;
         r_count         <= 5'd0;
         r_hold_regwrite <= ex.RegWriteE;
         r_hold_memtoreg <= ex.MemtoRegE;
         r_hold_memwrite <= ex.MemWriteE;
         r_hold_wreg     <= w_write_reg;
         r_hold_wdata    <= w_write_data;
      end else if (r_state == S_RUN) begin
         if (r_mul_b[0]) r_acc <= r_acc + r_mul_a;
         r_mul_a <= r_mul_a << 1;
         r_mul_b <= r_mul_b >> 1;
         r_count <= r_count + 5'd1;
      end
   end

   // Execute-to-memory register: live result, bubble while multiplying, product on DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex.RegWriteM  <= 1'b0;
         ex.MemtoRegM  <= 1'b0;
         ex.MemWriteM  <= 1'b0;
         ex.ALUOutM    <= 32'd0;
         ex.WriteDataM <= 32'd0;
         ex.WriteRegM  <= 5'd0;
      end else if (r_state == S_DONE) begin
         ex.RegWriteM  <= r_hold_regwrite;
         ex.MemtoRegM  <= r_hold_memtoreg;
         ex.MemWriteM  <= r_hold_memwrite;
         ex.ALUOutM    <= r_acc;
         ex.WriteDataM <= r_hold_wdata;
         ex.WriteRegM  <= r_hold_wreg;
      end else if (r_state == S_IDLE && !w_mul_op) begin
         ex.RegWriteM  <= ex.RegWriteE;
         ex.MemtoRegM  <= ex.MemtoRegE;
         ex.MemWriteM  <= ex.MemWriteE;
         ex.ALUOutM    <= w_alu_res;
         ex.WriteDataM <= w_write_data;
         ex.WriteRegM  <= w_write_reg;
      end else begin
         ex.RegWriteM  <= 1'b0;
         ex.MemtoRegM  <= 1'b0;
         ex.MemWriteM  <= 1'b0;
         ex.ALUOutM    <= 32'd0;
         ex.WriteDataM <= 32'd0;
         ex.WriteRegM  <= 5'd0;
      end
   end
endmodule
